// File: rtl/dense_neuron_engine_if.sv
// Stream, result and configuration bundle for dense_neuron_engine.
//   master: activation/weight feeder, configuration source and result consumer
//   slave : the engine itself
// Beat side   : i_valid/o_ready, i_last, i_act, i_wgt
// Config side : i_input_zp, i_filter_zp, i_output_zp, i_bias, i_quant_mult,
//               i_quant_shift, i_relu_en (held stable while o_busy=1)
// Result side : o_out_valid/i_out_ready, o_out
// Status      : o_beat_count, o_busy
interface dense_neuron_engine_if #(
  parameter int unsigned ACC_W = 32,
  parameter int unsigned CNT_W = 11
);
  logic                    i_valid;
  logic                    o_ready;
  logic                    i_last;
  logic signed [7:0]       i_act;
  logic signed [7:0]       i_wgt;
  logic signed [7:0]       i_input_zp;
  logic signed [7:0]       i_filter_zp;
  logic signed [7:0]       i_output_zp;
  logic signed [ACC_W-1:0] i_bias;
  logic signed [31:0]      i_quant_mult;
  logic signed [31:0]      i_quant_shift;
  logic                    i_relu_en;
  logic                    o_out_valid;
  logic                    i_out_ready;
  logic signed [7:0]       o_out;
  logic [CNT_W-1:0]        o_beat_count;
  logic                    o_busy;

  modport master (
    output i_valid, i_last, i_act, i_wgt,
    output i_input_zp, i_filter_zp, i_output_zp, i_bias,
    output i_quant_mult, i_quant_shift, i_relu_en, i_out_ready,
    input  o_ready, o_out_valid, o_out, o_beat_count, o_busy
  );

  modport slave (
    input  i_valid, i_last, i_act, i_wgt,
    input  i_input_zp, i_filter_zp, i_output_zp, i_bias,
    input  i_quant_mult, i_quant_shift, i_relu_en, i_out_ready,
    output o_ready, o_out_valid, o_out, o_beat_count, o_busy
  );
endinterface

// File: rtl/dense_neuron_engine.sv
// dense_neuron_engine: computes one int8 dense-layer output neuron from a
// stream of int8 activation/weight pairs (zero-point removal, 32-bit MAC,
// bias, optional ReLU, Q31 requantize with rounding, output zero-point).
// Ports:
//   i_clk  - clock
//   i_rst  - synchronous active-high reset
//   bus    - dense_neuron_engine_if.slave (beat stream, config, result, status)
// Optional build macro SATURATE_EN: clamp the final result to [-128,127]
// instead of truncating to the low 8 bits.
module dense_neuron_engine #(
  parameter int unsigned ACC_W = 32,
  parameter int unsigned CNT_W = 11
) (
  input logic                   i_clk,
  input logic                   i_rst,
  dense_neuron_engine_if.slave  bus
);

  localparam int unsigned P_W = 64;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_ACC,
    S_BIAS,
    S_MUL,
    S_SHIFT,
    S_OUT
  } state_t;

  state_t state, state_next;

  logic signed [ACC_W-1:0] acc;
  logic signed [P_W-1:0]   p64;

  logic signed [15:0]      a16;
  logic signed [15:0]      w16;
  logic signed [31:0]      prod32;
  logic signed [ACC_W-1:0] relu_acc;
  logic [5:0]              ts;
  logic signed [P_W-1:0]   p64_next;
  logic [7:0]              out_next;
  logic                    beat_fire;
  logic                    out_fire;
`ifdef SATURATE_EN
  logic signed [P_W-1:0]   sum64;
`endif

  assign beat_fire = bus.i_valid & bus.o_ready;
  assign out_fire  = bus.o_out_valid & bus.i_out_ready;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_ACC;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_ACC:   if (beat_fire && bus.i_last) state_next = S_BIAS;
      S_BIAS:  state_next = S_MUL;
      S_MUL:   state_next = S_SHIFT;
      S_SHIFT: state_next = S_OUT;
      S_OUT:   if (bus.i_out_ready) state_next = S_ACC;
      default: state_next = S_ACC;
    endcase
  end

  // Arithmetic for the MAC beat, requantize multiply and final shift
  always_comb begin
    a16      = {{8{bus.i_act[7]}}, bus.i_act} - {{8{bus.i_input_zp[7]}}, bus.i_input_zp};
    w16      = {{8{bus.i_wgt[7]}}, bus.i_wgt} - {{8{bus.i_filter_zp[7]}}, bus.i_filter_zp};
    prod32   = 32'(a16) * 32'(w16);
    relu_acc = (bus.i_relu_en && acc[ACC_W-1]) ? '0 : acc;
    // total right shift; legal quant_shift keeps this in 1..62
    ts       = 6'(32'sd31 - bus.i_quant_shift);
    p64_next = 64'(relu_acc) * 64'(bus.i_quant_mult) + (64'sd1 << (ts - 6'd1));
`ifdef SATURATE_EN
    sum64    = (p64 >>> ts) + 64'(bus.i_output_zp);
    if (sum64 > 64'sd127)       out_next = 8'h7F;
    else if (sum64 < -64'sd128) out_next = 8'h80;
    else                        out_next = sum64[7:0];
`else
    // low byte only: wraps exactly like the software golden model
    out_next = 8'(p64 >>> ts) + bus.i_output_zp;
`endif
  end

  // Datapath and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc              <= '0;
      p64              <= '0;
      bus.o_out        <= '0;
      bus.o_out_valid  <= 1'b0;
      bus.o_ready      <= 1'b1;
      bus.o_busy       <= 1'b0;
      bus.o_beat_count <= '0;
    end else begin
      bus.o_ready     <= (state_next == S_ACC);
      bus.o_out_valid <= (state_next == S_OUT);
      case (state)
        S_ACC: begin
          if (beat_fire) begin
            acc        <= acc + prod32;
            bus.o_busy <= 1'b1;
            if (bus.o_beat_count != CNT_MAX)
              bus.o_beat_count <= bus.o_beat_count + CNT_W'(1);
          end
        end
        S_BIAS:  acc <= acc + bus.i_bias;
        S_MUL:   p64 <= p64_next;
        S_SHIFT: bus.o_out <= out_next;
        S_OUT: begin
          if (out_fire) begin
            acc              <= '0;
            bus.o_beat_count <= '0;
            bus.o_busy       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_neuron_engine.sv
// Testbench for dense_neuron_engine: directed vectors with known results plus
// randomized vectors checked against an arithmetic reference model.
module tb_dense_neuron_engine;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  byte  q_act[$];
  byte  q_wgt[$];

  dense_neuron_engine_if #(.ACC_W(32), .CNT_W(11)) bus ();

  dense_neuron_engine #(.ACC_W(32), .CNT_W(11)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input byte izp, input byte fzp, input byte ozp, input int bias,
                     input int mult, input int shift, input bit relu);
    bus.i_input_zp    = izp;
    bus.i_filter_zp   = fzp;
    bus.i_output_zp   = ozp;
    bus.i_bias        = bias;
    bus.i_quant_mult  = mult;
    bus.i_quant_shift = shift;
    bus.i_relu_en     = relu;
  endtask

  // Reference: dot product with zero-points, wrapping 32-bit accumulate, then
  // bias, ReLU, rounded Q31 scaling and output zero-point.
  function automatic logic [7:0] model_out();
    int     acc;
    longint r;
    longint p;
    longint s;
    int     ts;
    acc = 0;
    foreach (q_act[i])
      acc += (int'(q_act[i]) - int'(bus.i_input_zp)) * (int'(q_wgt[i]) - int'(bus.i_filter_zp));
    acc += int'(bus.i_bias);
    r  = (bus.i_relu_en && acc < 0) ? 64'sd0 : longint'(acc);
    ts = 31 - int'(bus.i_quant_shift);
    p  = r * longint'(bus.i_quant_mult) + (longint'(1) << (ts - 1));
    s  = (p >>> ts) + longint'(bus.i_output_zp);
`ifdef SATURATE_EN
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
`endif
    return s[7:0];
  endfunction

  // Stream the queued beats, then check latency, result, stall hold and handshake.
  task automatic run_vec(input string tag, input int stall, input logic [7:0] exp);
    int n;
    int cyc;
    int exp_cnt;
    n = q_act.size();
    exp_cnt = (n > 2047) ? 2047 : n;
    for (int i = 0; i < n; i++) begin
      bus.i_valid = 1'b1;
      bus.i_act   = q_act[i];
      bus.i_wgt   = q_wgt[i];
      bus.i_last  = (i == n - 1);
      step();
    end
    // keep presenting junk beats; the engine must not consume them
    bus.i_act  = 8'sd85;
    bus.i_wgt  = -8'sd99;
    bus.i_last = 1'b0;
    chk({tag, ".ready_busy"}, 32'(bus.o_ready), 32'd0);
    chk({tag, ".busy"}, 32'(bus.o_busy), 32'd1);
    cyc = 0;
    while (!bus.o_out_valid && cyc < 12) begin
      step();
      cyc++;
    end
    chk({tag, ".latency"}, 32'(cyc), 32'd3);
    chk({tag, ".out"}, {24'd0, bus.o_out}, {24'd0, exp});
    chk({tag, ".count"}, 32'(bus.o_beat_count), 32'(exp_cnt));
    for (int i = 0; i < stall; i++) begin
      step();
      chk({tag, ".hold_valid"}, 32'(bus.o_out_valid), 32'd1);
      chk({tag, ".hold_out"}, {24'd0, bus.o_out}, {24'd0, exp});
      chk({tag, ".hold_ready"}, 32'(bus.o_ready), 32'd0);
    end
    bus.i_valid     = 1'b0;
    bus.i_out_ready = 1'b1;
    step();
    bus.i_out_ready = 1'b0;
    chk({tag, ".post_valid"}, 32'(bus.o_out_valid), 32'd0);
    chk({tag, ".post_ready"}, 32'(bus.o_ready), 32'd1);
    chk({tag, ".post_busy"}, 32'(bus.o_busy), 32'd0);
    chk({tag, ".post_count"}, 32'(bus.o_beat_count), 32'd0);
    q_act.delete();
    q_wgt.delete();
  endtask

  initial begin
    logic [7:0] exp;
    int n;
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_last = 1'b0;
    bus.i_act = '0;
    bus.i_wgt = '0;
    bus.i_out_ready = 1'b0;
    cfg(0, 0, 0, 0, 32'h4000_0000, 0, 1'b1);
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst.ready", 32'(bus.o_ready), 32'd1);
    chk("rst.valid", 32'(bus.o_out_valid), 32'd0);
    chk("rst.out", {24'd0, bus.o_out}, 32'd0);
    chk("rst.count", 32'(bus.o_beat_count), 32'd0);
    chk("rst.busy", 32'(bus.o_busy), 32'd0);

    // 1: single beat 10*3 scaled by 0.5 with rounding
    cfg(0, 0, 0, 0, 32'h4000_0000, 0, 1'b1);
    q_act.push_back(8'sd10); q_wgt.push_back(8'sd3);
    run_vec("t1", 0, 8'h0F);

    // 2: zero-points, bias, shift and output zero-point
    cfg(-8'sd3, 8'sd1, -8'sd10, 100, 32'h4000_0000, 1, 1'b1);
    q_act.push_back(8'sd5); q_wgt.push_back(8'sd2);
    run_vec("t2", 1, 8'd98);

    // 3: ReLU clamps negative sum; without ReLU rounding goes toward -inf
    cfg(0, 0, 8'sd7, 0, 32'h4000_0000, 0, 1'b1);
    q_act.push_back(-8'sd4); q_wgt.push_back(8'sd5);
    run_vec("t3a", 0, 8'd7);
    cfg(0, 0, 0, 0, 32'h4000_0000, 0, 1'b0);
    q_act.push_back(-8'sd4); q_wgt.push_back(8'sd5);
    run_vec("t3b", 0, 8'hF6);

    // 4: result overflows int8
    cfg(0, 0, 0, 0, 32'h4000_0000, 0, 1'b1);
    q_act.push_back(8'sd127); q_wgt.push_back(8'sd127);
`ifdef SATURATE_EN
    run_vec("t4", 0, 8'h7F);
`else
    run_vec("t4", 0, 8'h81);
`endif

    // 5: full MNIST-length vector with downstream stall
    cfg(0, 0, 0, 0, 32'h7FFF_FFFF, 0, 1'b1);
    for (int i = 0; i < 784; i++) begin
      q_act.push_back(8'sd1); q_wgt.push_back(8'sd1);
    end
`ifdef SATURATE_EN
    run_vec("t5", 5, 8'h7F);
`else
    run_vec("t5", 5, 8'h10);
`endif

    // 6: reset discards a partial vector
    cfg(0, 0, 0, 0, 32'h4000_0000, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      bus.i_valid = 1'b1;
      bus.i_act   = 8'sd10;
      bus.i_wgt   = 8'sd10;
      bus.i_last  = 1'b0;
      step();
    end
    chk("t6.count_pre", 32'(bus.o_beat_count), 32'd3);
    bus.i_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6.rst_count", 32'(bus.o_beat_count), 32'd0);
    chk("t6.rst_busy", 32'(bus.o_busy), 32'd0);
    q_act.push_back(8'sd2); q_wgt.push_back(8'sd3);
    run_vec("t6", 0, 8'd3);

    // Beat counter saturation (sum stays zero, result is the output zero-point)
    cfg(0, 0, 8'sd5, 0, 32'h4000_0000, 0, 1'b0);
    for (int i = 0; i < 2050; i++) begin
      q_act.push_back(8'sd1); q_wgt.push_back(8'sd0);
    end
    run_vec("sat_cnt", 0, 8'd5);

    // Randomized vectors against the reference model
    for (int v = 0; v < 12; v++) begin
      cfg(byte'($urandom), byte'($urandom), byte'($urandom), int'($urandom),
          int'($urandom), int'($urandom_range(61, 0)) - 31, 1'($urandom_range(1, 0)));
      n = int'($urandom_range(24, 1));
      for (int i = 0; i < n; i++) begin
        q_act.push_back(byte'($urandom));
        q_wgt.push_back(byte'($urandom));
      end
      exp = model_out();
      run_vec($sformatf("rnd%0d", v), int'($urandom_range(3, 0)), exp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
